preamble_frame_tx: RTL and testbench
====================================

# preamble_frame_tx

Serial frame transmitter producing the bitstream consumed by the team's 1010 sequence detector. Each accepted parallel word is sent MSB-first on a single-bit line, preceded by a fixed 4-bit `1010` preamble and followed by an idle gap. The detector on the far end fires on the preamble. A valid/ready handshake on the parallel side accepts one frame at a time from upstream logic.

## Interface
- `DATA_WIDTH`, 8: payload bits per frame (≥1).
- `PREAMBLE`, 4'b1010: preamble pattern, sent bit 3 first.
- `GAP_CYCLES`, 1: idle-low cycles after each payload (≥1).
- `clk`  in  1  clock; all state changes on the rising edge.
- `reset`  in  1  asynchronous, active-high reset.
- `tx_data`  in  DATA_WIDTH  payload word, sampled at handshake.
- `tx_valid`  in  1  upstream has a word.
- `tx_ready`  out  1  block can accept a word (high only in IDLE).
- `serial_out`  out  1  registered serial line; idle level 0.
- `frame_active`  out  1  high while preamble or payload bits are driven.
- `frame_done`  out  1  one-cycle pulse coincident with the last payload bit.

## Operation
- States:
  - IDLE: `serial_out`=0, `tx_ready`=1.
  - PRE: 4 cycles.
  - DATA: DATA_WIDTH cycles.
  - GAP: GAP_CYCLES cycles, `serial_out`=0.
- Transitions:
  - IDLE→PRE on rising edge with `tx_valid`&`tx_ready`. `tx_data` is latched into the shift register at that edge.
  - PRE→DATA after bit 0 of the preamble.
  - DATA→GAP after the payload LSB.
  - GAP→IDLE after the last gap cycle.
- Bit counter reloads on every state entry. Width is ceil(log2(max(4, DATA_WIDTH, GAP_CYCLES))) bits. Its terminal count is compared exactly, with no wrap past it.
- `tx_data` and `tx_valid` are ignored outside IDLE. Upstream changes after the handshake do not affect the frame in flight.
- `tx_valid` held high continuously produces back-to-back frames separated only by the gap and one IDLE cycle.
- `frame_active` = state is PRE or DATA. It is registered together with `serial_out`, so the two stay aligned.
- Reset values: state IDLE, `serial_out`=0, `frame_active`=0, `frame_done`=0, shift register 0, counter 0. `tx_ready` reads 1 throughout reset. Handshakes while `reset` is high are ignored.
- Reset mid-frame:
  - Outputs drop to reset values immediately, asynchronously.
  - The partial frame is abandoned, not resumed.
  - A new handshake is possible on the first rising edge after deassertion.

## Timing
- The handshake edge is E0; cycle n is the cycle after edge En.
- `serial_out`:
  - PREAMBLE[3..0] in cycles 1–4.
  - Payload bits DATA_WIDTH-1..0 in cycles 5 to 4+DATA_WIDTH.
  - 0 in the GAP cycles.
- `frame_active`: high in cycles 1 to 4+DATA_WIDTH.
- `frame_done`: high only in cycle 4+DATA_WIDTH (cycle 12 at defaults).
- `tx_ready`: low in cycles 1 to 4+DATA_WIDTH+GAP_CYCLES, high again the cycle after.
- Minimum handshake-to-handshake period: 4+DATA_WIDTH+GAP_CYCLES+1 cycles (14 at defaults).
- Latency from handshake to first preamble bit: 1 cycle.

## Test plan
- Reset, then single frame, `tx_data`=8'hA5 → `serial_out` cycles 1–13 = 1,0,1,0,1,0,1,0,0,1,0,1,0; `frame_done` high only in cycle 12; `tx_ready` back high in cycle 14.
- `tx_valid` held high with words 8'hFF then 8'h00 → second handshake exactly 14 cycles after the first. Line shows 1010 11111111 0, then 1010 00000000 0.
- `tx_valid` pulsed and `tx_data` changed to 8'h3C during cycles 3–10 of a frame for 8'h81 → frame still carries 10000001; no extra frame starts.
- `reset` asserted mid-edge during cycle 7 of a frame → `serial_out`, `frame_active`, `frame_done` go 0 without a clock. After release, a new 8'h5A handshake starts a full clean frame.
- Parameters DATA_WIDTH=4, GAP_CYCLES=3, word 4'b1010 → line 1010 1010 000; `frame_done` in cycle 8; a downstream 1010 detector flags both the preamble and the payload.
- Idle with `tx_valid`=0 for 20 cycles after reset → `serial_out`=0, `frame_active`=0, `tx_ready`=1 throughout.

Source files
------------

// File: rtl/preamble_frame_tx.sv
// Serial frame transmitter: 4-bit preamble, MSB-first payload, idle-low gap.
// Valid/ready handshake accepts one word per frame while idle.
module preamble_frame_tx #(
  parameter int          DATA_WIDTH = 8,
  parameter logic [3:0]  PREAMBLE   = 4'b1010,
  parameter int          GAP_CYCLES = 1
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic [DATA_WIDTH-1:0] tx_data,
  input  logic                  tx_valid,
  output logic                  tx_ready,
  output logic                  serial_out,
  output logic                  frame_active,
  output logic                  frame_done
);

  localparam int SW = DATA_WIDTH + 4;
  localparam int M1 = (DATA_WIDTH > 4) ? DATA_WIDTH : 4;
  localparam int MC = (GAP_CYCLES > M1) ? GAP_CYCLES : M1;
  localparam int CW = $clog2(MC);

  localparam logic [CW-1:0] PRE_LAST  = CW'(3);
  localparam logic [CW-1:0] DATA_LAST = CW'(DATA_WIDTH - 1);
  localparam logic [CW-1:0] DATA_PEN  = CW'(DATA_WIDTH - 2);
  localparam logic [CW-1:0] GAP_LAST  = CW'(GAP_CYCLES - 1);

  typedef enum logic [1:0] {
    IDLE,
    PRE,
    DATA,
    GAP
  } state_t;

  state_t          state_q, state_d;
  logic [CW-1:0]   cnt_q, cnt_d;
  logic [SW-1:0]   shift_q, shift_d;
  logic            ser_q, ser_d;
  logic            act_q, act_d;
  logic            done_q, done_d;

  // Preamble and payload share one shift register so the line is
  // always the register MSB while a frame is being driven.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    shift_d = shift_q;
    ser_d   = 1'b0;
    act_d   = 1'b0;
    done_d  = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (tx_valid) begin
          state_d = PRE;
          cnt_d   = '0;
          shift_d = {PREAMBLE[2:0], tx_data, 1'b0};
          ser_d   = PREAMBLE[3];
          act_d   = 1'b1;
        end
      end
      PRE: begin
        ser_d   = shift_q[SW-1];
        shift_d = {shift_q[SW-2:0], 1'b0};
        act_d   = 1'b1;
        if (cnt_q == PRE_LAST) begin
          state_d = DATA;
          cnt_d   = '0;
          done_d  = (DATA_WIDTH == 1);
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end
      DATA: begin
        if (cnt_q == DATA_LAST) begin
          state_d = GAP;
          cnt_d   = '0;
        end else begin
          ser_d   = shift_q[SW-1];
          shift_d = {shift_q[SW-2:0], 1'b0};
          act_d   = 1'b1;
          done_d  = (cnt_q == DATA_PEN);
          cnt_d   = cnt_q + CW'(1);
        end
      end
      GAP: begin
        if (cnt_q == GAP_LAST) begin
          state_d = IDLE;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      shift_q <= '0;
      ser_q   <= 1'b0;
      act_q   <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      shift_q <= shift_d;
      ser_q   <= ser_d;
      act_q   <= act_d;
      done_q  <= done_d;
    end
  end

  assign tx_ready     = (state_q == IDLE);
  assign serial_out   = ser_q;
  assign frame_active = act_q;
  assign frame_done   = done_q;

endmodule

// File: tb/tb_preamble_frame_tx.sv
// Bench for preamble_frame_tx: frame-queue reference model, vector table,
// directed corner sequences and a narrow-payload instance.
module tb_preamble_frame_tx;

  logic       clk;
  logic       reset;
  logic [7:0] tx_data;
  logic       tx_valid;
  logic       tx_ready;
  logic       serial_out;
  logic       frame_active;
  logic       frame_done;

  logic       r4;
  logic [3:0] d4;
  logic       v4;
  logic       rdy4;
  logic       ser4;
  logic       act4;
  logic       done4;

  int checks = 0;
  int errors = 0;

  logic [3:0] obs;
  logic [3:0] obs4;
  logic [3:0] q[$];

  assign obs  = {serial_out, frame_active, frame_done, tx_ready};
  assign obs4 = {ser4, act4, done4, rdy4};

  preamble_frame_tx u_dut (
    .clk          (clk),
    .reset        (reset),
    .tx_data      (tx_data),
    .tx_valid     (tx_valid),
    .tx_ready     (tx_ready),
    .serial_out   (serial_out),
    .frame_active (frame_active),
    .frame_done   (frame_done)
  );

  preamble_frame_tx #(
    .DATA_WIDTH (4),
    .PREAMBLE   (4'b1010),
    .GAP_CYCLES (3)
  ) u_dut4 (
    .clk          (clk),
    .reset        (r4),
    .tx_data      (d4),
    .tx_valid     (v4),
    .tx_ready     (rdy4),
    .serial_out   (ser4),
    .frame_active (act4),
    .frame_done   (done4)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [15:0] got,
                     input logic [15:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%h exp=%h", nm, got, exp);
    end
  endtask

  // One frame as seen on the line, one entry per cycle, then the idle cycle.
  task automatic push_frame(input logic [7:0] d);
    logic [3:0] pre_v;
    pre_v = 4'b1010;
    for (int k = 0; k < 4; k++)
      q.push_back({pre_v[3-k], 1'b1, 1'b0, 1'b0});
    for (int k = 0; k < 8; k++)
      q.push_back({d[7-k], 1'b1, (k == 7), 1'b0});
    q.push_back(4'b0000);
    q.push_back(4'b0001);
  endtask

  task automatic tick(input string nm);
    logic       hs;
    logic [3:0] e;
    hs = (q.size() == 0) && tx_valid && !reset;
    @(posedge clk);
    #1;
    if (reset) q.delete();
    else if (hs) push_frame(tx_data);
    e = (q.size() != 0) ? q.pop_front() : 4'b0001;
    chk(nm, {12'd0, obs}, {12'd0, e});
  endtask

  typedef struct {
    logic       v;
    logic [7:0] d;
    logic [3:0] e;
  } vec_t;

  vec_t        tbl[14];
  logic [12:0] sbits;
  logic [10:0] sbits4;
  logic [7:0]  pay;
  logic [3:0]  win;
  logic [12:0] det;
  logic [3:0]  e4;

  initial begin
    reset    = 1'b1;
    tx_valid = 1'b1;
    tx_data  = 8'hA5;
    r4       = 1'b1;
    v4       = 1'b0;
    d4       = 4'd0;

    // handshakes under reset are ignored
    tick("rst_hold0");
    chk("rst_ready", {15'd0, tx_ready}, 16'd1);
    tick("rst_hold1");
    reset    = 1'b0;
    tx_valid = 1'b0;
    repeat (20) tick("idle");

    // single A5 frame against a literal table
    sbits = 13'b1010101001010;
    for (int i = 0; i < 13; i++) begin
      tbl[i].v = (i == 0);
      tbl[i].d = (i == 0) ? 8'hA5 : 8'h3C;
      tbl[i].e = {sbits[12-i], (i < 12), (i == 11), 1'b0};
    end
    tbl[13].v = 1'b0;
    tbl[13].d = 8'h00;
    tbl[13].e = 4'b0001;
    for (int i = 0; i < 14; i++) begin
      tx_valid = tbl[i].v;
      tx_data  = tbl[i].d;
      tick("a5_model");
      chk($sformatf("a5_tbl_c%0d", i + 1), {12'd0, obs}, {12'd0, tbl[i].e});
    end

    // back-to-back frames with valid held high
    tx_valid = 1'b1;
    tx_data  = 8'hFF;
    tick("b2b_first");
    tx_data = 8'h00;
    repeat (13) tick("b2b_frame1");
    chk("b2b_idle_c14", {12'd0, obs}, 16'h0001);
    tick("b2b_second");
    chk("b2b_second_c15", {12'd0, obs}, 16'h000C);
    tx_valid = 1'b0;
    repeat (13) tick("b2b_frame2");

    // upstream noise during a frame is ignored
    tx_valid = 1'b1;
    tx_data  = 8'h81;
    tick("ign_hs");
    pay = 8'h00;
    for (int c = 2; c <= 14; c++) begin
      if (c >= 3 && c <= 10) begin
        tx_valid = 1'($urandom_range(0, 1));
        tx_data  = 8'h3C;
      end else begin
        tx_valid = 1'b0;
      end
      tick("ign_frame");
      if (c >= 5 && c <= 12) pay = {pay[6:0], serial_out};
    end
    chk("ign_payload", {8'd0, pay}, 16'h0081);
    repeat (4) tick("ign_after");

    // asynchronous reset in the middle of the payload
    tx_valid = 1'b1;
    tx_data  = 8'hFF;
    tick("mrst_hs");
    tx_valid = 1'b0;
    repeat (6) tick("mrst_run");
    chk("mrst_pre_c7", {12'd0, obs}, 16'h000C);
    #3;
    reset = 1'b1;
    #1;
    chk("mrst_async", {12'd0, obs}, 16'h0001);
    q.delete();
    tick("mrst_held");
    reset    = 1'b0;
    tx_valid = 1'b1;
    tx_data  = 8'h5A;
    tick("mrst_new_hs");
    chk("mrst_new_c1", {12'd0, obs}, 16'h000C);
    tx_valid = 1'b0;
    repeat (13) tick("mrst_new_frame");

    // randomized traffic with occasional resets
    for (int n = 0; n < 400; n++) begin
      tx_valid = ($urandom_range(0, 3) != 0);
      tx_data  = 8'($urandom);
      reset    = ($urandom_range(0, 99) == 0);
      tick("rand");
    end
    reset    = 1'b0;
    tx_valid = 1'b0;
    repeat (16) tick("rand_drain");

    // narrow payload, longer gap
    r4 = 1'b0;
    @(posedge clk);
    #1;
    v4 = 1'b1;
    d4 = 4'b1010;
    @(posedge clk);
    #1;
    v4     = 1'b0;
    sbits4 = 11'b10101010000;
    win    = 4'd0;
    det    = 13'd0;
    for (int i = 1; i <= 12; i++) begin
      if (i <= 11) e4 = {sbits4[11-i], (i <= 8), (i == 8), 1'b0};
      else e4 = 4'b0001;
      chk($sformatf("w4_c%0d", i), {12'd0, obs4}, {12'd0, e4});
      win = {win[2:0], ser4};
      if (win == 4'b1010) det[i] = 1'b1;
      if (i < 12) begin
        @(posedge clk);
        #1;
      end
    end
    chk("w4_det_pre", {15'd0, det[4]}, 16'd1);
    chk("w4_det_pay", {15'd0, det[8]}, 16'd1);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
